seq_mult_ls_param: RTL and testbench

- Parametrised unsigned/signed sequential shift-add multiplier using a left-shifting multiplicand.
- Generalised successor to the fixed 6-bit left-shift multiplier: WIDTH-bit operands, start/busy/done handshake, registered 2*WIDTH-bit product, per-operation signed mode.
- Sits between operand registers (or a switch/button front end) and a display or consumer.
- Runs on the already-divided slow `clk`; contains no clock divider.

---
 rtl/seq_mult_ls_param.sv | 129 ++++++++++++
 tb/tb_seq_mult_ls_param.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult_ls_param.sv
// rtl/seq_mult_ls_param.sv - sequential shift-add multiplier with a left-shifting multiplicand
// Optional early termination on an exhausted multiplier: SEQ_MULT_EARLY_TERM_EN.
module seq_mult_ls_param #(
  parameter int WIDTH = 6,
  parameter int CNT_W = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 sgn,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic [WIDTH-1:0]     X,
  output logic [2*WIDTH-1:0]   Y
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t               state;
  state_t               state_nxt;
  logic [WIDTH-1:0]     a_q;
  logic [WIDTH-1:0]     b_q;
  logic                 sgn_q;
  logic                 neg_q;
  logic [2*WIDTH-1:0]   acc;
  logic [2*WIDTH-1:0]   acc_nxt;
  logic [2*WIDTH-1:0]   prod_nxt;
  logic [CNT_W-1:0]     cnt;
  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic                 iter_last;

  // Magnitudes: the most-negative value negates to itself, which reads correctly as unsigned.
  always_comb begin
    a_mag     = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
    b_mag     = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
    acc_nxt   = X[0] ? (acc + Y) : acc;
    prod_nxt  = neg_q ? -acc_nxt : acc_nxt;
    iter_last = (cnt == LAST_ITER);
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        busy = 1'b1;
`ifdef SEQ_MULT_EARLY_TERM_EN
        state_nxt = (b_mag == '0) ? S_DONE : S_RUN;
`else
        state_nxt = S_RUN;
`endif
      end
      S_RUN: begin
        busy = 1'b1;
`ifdef SEQ_MULT_EARLY_TERM_EN
        if (X == '0 || iter_last) state_nxt = S_DONE;
`else
        if (iter_last) state_nxt = S_DONE;
`endif
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      neg_q   <= 1'b0;
      acc     <= '0;
      cnt     <= '0;
      product <= '0;
      X       <= '0;
      Y       <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            a_q   <= a;
            b_q   <= b;
            sgn_q <= sgn;
          end
        end
        S_LOAD: begin
          neg_q <= sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
          Y     <= {{WIDTH{1'b0}}, a_mag};
          X     <= b_mag;
          acc   <= '0;
          cnt   <= '0;
`ifdef SEQ_MULT_EARLY_TERM_EN
          if (b_mag == '0) product <= '0;
`endif
        end
        S_RUN: begin
          acc <= acc_nxt;
          Y   <= Y << 1;
          X   <= X >> 1;
          cnt <= cnt + 1'b1;
          // Product is registered on entry to DONE so it is valid alongside the done pulse.
          if (state_nxt == S_DONE) product <= prod_nxt;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_ls_param.sv
// tb/tb_seq_mult_ls_param.sv - scoreboard bench for seq_mult_ls_param
module tb_seq_mult_ls_param;

  localparam int W = 6;

  typedef struct {
    logic [2*W-1:0] prod;
    int             done_cyc;
    int             lat;
  } exp_t;

  logic             clk;
  logic             rst;
  logic             start;
  logic             sgn;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;
  logic [W-1:0]     x_dbg;
  logic [2*W-1:0]   y_dbg;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fails = 0;
  int   busy_cnt = 0;
  exp_t sb[$];

  seq_mult_ls_param #(.WIDTH(W), .CNT_W(6)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .sgn     (sgn),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .X       (x_dbg),
    .Y       (y_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] ma, input logic [W-1:0] mb);
    longint sa, sbv, p;
    logic [63:0] pv;
    sa  = s ? longint'($signed(ma)) : longint'(ma);
    sbv = s ? longint'($signed(mb)) : longint'(mb);
    p   = sa * sbv;
    pv  = p;
    return pv[2*W-1:0];
  endfunction

  function automatic int latency(input logic s, input logic [W-1:0] mb);
`ifdef SEQ_MULT_EARLY_TERM_EN
    logic [W-1:0] mag;
    int hb;
    mag = (s && mb[W-1]) ? -mb : mb;
    if (mag == '0) return 2;
    hb = 0;
    for (int i = 0; i < W; i++) if (mag[i]) hb = i;
    return 2 + (hb + 1) + 1;
`else
    return W + 2;
`endif
  endfunction

  task automatic push_exp(input logic s, input logic [W-1:0] ma, input logic [W-1:0] mb, input int at_cyc);
    exp_t e;
    e.prod     = model(s, ma, mb);
    e.lat      = latency(s, mb);
    e.done_cyc = at_cyc + e.lat;
    sb.push_back(e);
  endtask

  // Drives one start cycle, then scrambles the operands to prove they were captured.
  task automatic do_op(input logic s, input logic [W-1:0] ma, input logic [W-1:0] mb, input bit expect_result);
    @(negedge clk);
    sgn = s; a = ma; b = mb; start = 1'b1;
    if (expect_result) push_exp(s, ma, mb, cyc);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); sgn = 1'($urandom);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (busy) busy_cnt++;
    else if (!done) busy_cnt = 0;
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", done, 1'b0);
      end else begin
        e = sb.pop_front();
        check("product", product, e.prod);
        check("done_cycle", cyc, e.done_cyc);
        check("busy_cycles", busy_cnt, e.lat - 1);
      end
      busy_cnt = 0;
    end
  end

  initial begin
    int s0;
    int lat;
    rst = 1'b0; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_product", product, '0);
    check("rst_x", x_dbg, '0);
    check("rst_y", y_dbg, '0);
    rst = 1'b1;
    @(negedge clk);

    do_op(1'b0, 6'd63, 6'd63, 1'b1);
    wait_drain();
    check("max_unsigned", product, 12'hF81);

    do_op(1'b1, 6'b111011, 6'd7, 1'b1);
    wait_drain();
    check("neg5_x_7", product, 12'hFDD);
    do_op(1'b1, 6'b100000, 6'b100000, 1'b1);
    wait_drain();
    check("minneg_sq", product, 12'h400);

    do_op(1'b0, 6'd0, 6'd45, 1'b1);
    repeat (2) @(negedge clk);
    check("product_hold", product, 12'h400);
    wait_drain();
    do_op(1'b0, 6'd45, 6'd0, 1'b1);
    wait_drain();
    check("b_zero", product, '0);

    do_op(1'b0, 6'd21, 6'd13, 1'b1);
    repeat (2) @(negedge clk);
    sgn = 1'b0; a = 6'd5; b = 6'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();
    repeat (12) @(negedge clk);
    check("ignored_start", product, 12'd273);

    do_op(1'b0, 6'd33, 6'd17, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midrun_busy", busy, 1'b0);
    check("midrun_done", done, 1'b0);
    check("midrun_product", product, '0);
    do_op(1'b0, 6'd12, 6'd10, 1'b1);
    wait_drain();
    check("after_reset", product, 12'd120);

    // Start held high: two back-to-back operations on the same operands.
    @(negedge clk);
    sgn = 1'b1; a = 6'b110110; b = 6'd11; start = 1'b1;
    s0  = cyc;
    lat = latency(1'b1, 6'd11);
    push_exp(1'b1, 6'b110110, 6'd11, s0);
    push_exp(1'b1, 6'b110110, 6'd11, s0 + lat + 1);
    repeat (lat + 2) @(negedge clk);
    start = 1'b0;
    wait_drain();

    for (int i = 0; i < 8; i++) begin
      do_op(1'($urandom), W'($urandom), W'($urandom), 1'b1);
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
